// File: rtl/yarp_load_wb.sv
// YARP writeback stage: ALU results retire in one cycle; loads run a
// request/grant/response transaction, then byte-select and extend.
module yarp_load_wb (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [4:0]  rd_addr_i,
  input  logic        is_load_i,
  input  logic [1:0]  load_size_i,
  input  logic        load_zext_i,
  input  logic [31:0] alu_res_i,
  output logic        dmem_req_o,
  output logic [31:0] dmem_addr_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wr_en_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] wr_data_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t      state;
  logic [4:0]  ld_rd;
  logic [1:0]  ld_size;
  logic        ld_zext;
  logic [1:0]  ld_off;
  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign ready_o = (state == IDLE);

  // Half needs addr[0]=0; word (size 10 or 11) needs addr[1:0]=0.
  assign misaligned = ((load_size_i == 2'b01) && alu_res_i[0]) ||
                      (load_size_i[1] && (alu_res_i[1:0] != 2'b00));

  always_comb begin
    ld_byte = '0;
    ld_half = '0;
    ld_ext  = dmem_rdata_i;
    case (ld_off)
      2'b00:   ld_byte = dmem_rdata_i[7:0];
      2'b01:   ld_byte = dmem_rdata_i[15:8];
      2'b10:   ld_byte = dmem_rdata_i[23:16];
      default: ld_byte = dmem_rdata_i[31:24];
    endcase
    ld_half = ld_off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    if (ld_size == 2'b00)
      ld_ext = {{24{ld_byte[7] & ~ld_zext}}, ld_byte};
    else if (ld_size == 2'b01)
      ld_ext = {{16{ld_half[15] & ~ld_zext}}, ld_half};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dmem_req_o  <= 1'b0;
      dmem_addr_o <= '0;
      wr_en_o     <= 1'b0;
      rd_addr_o   <= '0;
      wr_data_o   <= '0;
      misalign_o  <= 1'b0;
      ld_rd       <= '0;
      ld_size     <= '0;
      ld_zext     <= 1'b0;
      ld_off      <= '0;
    end else begin
      wr_en_o    <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (!is_load_i) begin
              // Writes to x0 are suppressed; outputs keep their last value.
              if (rd_addr_i != 5'd0) begin
                wr_en_o   <= 1'b1;
                rd_addr_o <= rd_addr_i;
                wr_data_o <= alu_res_i;
              end
            end else if (misaligned) begin
              misalign_o <= 1'b1;
            end else begin
              ld_rd       <= rd_addr_i;
              ld_size     <= load_size_i;
              ld_zext     <= load_zext_i;
              ld_off      <= alu_res_i[1:0];
              dmem_addr_o <= {alu_res_i[31:2], 2'b00};
              dmem_req_o  <= 1'b1;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            if (ld_rd != 5'd0) begin
              wr_en_o   <= 1'b1;
              rd_addr_o <= ld_rd;
              wr_data_o <= ld_ext;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yarp_load_wb.sv
// Directed self-checking bench for the yarp_load_wb writeback stage.
module tb_yarp_load_wb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  rd_addr_i;
  logic        is_load_i;
  logic [1:0]  load_size_i;
  logic        load_zext_i;
  logic [31:0] alu_res_i;
  logic        dmem_req_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wr_en_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] wr_data_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  yarp_load_wb dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .rd_addr_i    (rd_addr_i),
    .is_load_i    (is_load_i),
    .load_size_i  (load_size_i),
    .load_zext_i  (load_zext_i),
    .alu_res_i    (alu_res_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_gnt_i   (dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i (dmem_rdata_i),
    .wr_en_o      (wr_en_o),
    .rd_addr_o    (rd_addr_o),
    .wr_data_o    (wr_data_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  // Presents one instruction for one accepting edge; returns at the
  // falling edge of the following cycle.
  task automatic issue(input logic [4:0] rd, input logic ld, input logic [1:0] sz,
                       input logic zx, input logic [31:0] a);
    valid_i = 1'b1; rd_addr_i = rd; is_load_i = ld;
    load_size_i = sz; load_zext_i = zx; alu_res_i = a;
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  // Memory side of a load already in REQ: grant after gd cycles, rvalid
  // gd+1+rvd cycles later. Returns at the falling edge of the write cycle.
  task automatic run_mem(input int gd, input int rvd, input logic [31:0] rdata,
                         output logic stable, output logic wait_ok);
    logic [31:0] a0;
    stable = 1'b1; wait_ok = 1'b1; a0 = dmem_addr_o;
    for (int i = 0; i < gd; i++) begin
      if (dmem_req_o !== 1'b1 || dmem_addr_o !== a0 || ready_o !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    if (dmem_req_o !== 1'b1 || dmem_addr_o !== a0 || ready_o !== 1'b0) stable = 1'b0;
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    for (int i = 0; i <= rvd; i++) begin
      if (dmem_req_o !== 1'b0 || ready_o !== 1'b0 || wr_en_o !== 1'b0) wait_ok = 1'b0;
      if (i == rvd) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata; end
      @(negedge clk);
    end
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; valid_i = 1'b0; rd_addr_i = '0; is_load_i = 1'b0;
    load_size_i = '0; load_zext_i = 1'b0; alu_res_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    #3;
    total++;
    if ({ready_o, dmem_req_o, dmem_addr_o, wr_en_o, rd_addr_o, wr_data_o, misalign_o} !==
        {1'b1, 1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: rdy=%b req=%b addr=%h we=%b rd=%h wd=%h mis=%b, want rdy=1 rest 0",
               ready_o, dmem_req_o, dmem_addr_o, wr_en_o, rd_addr_o, wr_data_o, misalign_o);
    end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu();
    issue(5'd5, 1'b0, 2'b10, 1'b0, 32'hDEADBEEF);
    total++;
    if ({wr_en_o, rd_addr_o, wr_data_o, ready_o} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1}) begin
      bad++;
      $display("FAIL alu_write: we=%b rd=%0d wd=%h rdy=%b, want 1 5 deadbeef 1",
               wr_en_o, rd_addr_o, wr_data_o, ready_o);
    end
    @(negedge clk);
    total++;
    if (wr_en_o !== 1'b0 || wr_data_o !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL alu_one_cycle: we=%b wd=%h, want 0 deadbeef", wr_en_o, wr_data_o);
    end
    issue(5'd0, 1'b0, 2'b10, 1'b0, 32'h11111111);
    total++;
    if (wr_en_o !== 1'b0 || rd_addr_o !== 5'd5 || wr_data_o !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL alu_x0: we=%b rd=%0d wd=%h, want 0 5 deadbeef", wr_en_o, rd_addr_o, wr_data_o);
    end
  endtask

  task automatic test_lb();
    logic st, wo;
    issue(5'd3, 1'b1, 2'b00, 1'b0, 32'h00001003);
    total++;
    if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h00001000 || ready_o !== 1'b0) begin
      bad++;
      $display("FAIL lb_req: req=%b addr=%h rdy=%b, want 1 00001000 0", dmem_req_o, dmem_addr_o, ready_o);
    end
    run_mem(0, 0, 32'h80123456, st, wo);
    total++;
    if ({wr_en_o, rd_addr_o, wr_data_o, st, wo} !== {1'b1, 5'd3, 32'hFFFFFF80, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL lb_sext: we=%b rd=%0d wd=%h st=%b wo=%b, want 1 3 ffffff80 1 1",
               wr_en_o, rd_addr_o, wr_data_o, st, wo);
    end
    issue(5'd3, 1'b1, 2'b00, 1'b1, 32'h00001003);
    run_mem(0, 0, 32'h80123456, st, wo);
    total++;
    if (wr_en_o !== 1'b1 || wr_data_o !== 32'h00000080) begin
      bad++;
      $display("FAIL lbu_zext: we=%b wd=%h, want 1 00000080", wr_en_o, wr_data_o);
    end
    issue(5'd4, 1'b1, 2'b00, 1'b0, 32'h00001001);
    run_mem(0, 0, 32'h00007F00, st, wo);
    total++;
    if (wr_en_o !== 1'b1 || rd_addr_o !== 5'd4 || wr_data_o !== 32'h0000007F) begin
      bad++;
      $display("FAIL lb_off1: we=%b rd=%0d wd=%h, want 1 4 0000007f", wr_en_o, rd_addr_o, wr_data_o);
    end
  endtask

  task automatic test_lh_delayed();
    logic st, wo;
    issue(5'd10, 1'b1, 2'b01, 1'b0, 32'h00002002);
    total++;
    if (dmem_addr_o !== 32'h00002000) begin
      bad++;
      $display("FAIL lh_addr: addr=%h, want 00002000", dmem_addr_o);
    end
    run_mem(4, 2, 32'h8001ABCD, st, wo);
    total++;
    if ({st, wo} !== 2'b11) begin
      bad++;
      $display("FAIL lh_handshake: stable=%b wait_ok=%b, want 1 1", st, wo);
    end
    total++;
    if ({wr_en_o, rd_addr_o, wr_data_o} !== {1'b1, 5'd10, 32'hFFFF8001}) begin
      bad++;
      $display("FAIL lh_sext: we=%b rd=%0d wd=%h, want 1 10 ffff8001", wr_en_o, rd_addr_o, wr_data_o);
    end
    issue(5'd11, 1'b1, 2'b01, 1'b1, 32'h00002000);
    run_mem(1, 0, 32'h1234F00D, st, wo);
    total++;
    if (wr_en_o !== 1'b1 || wr_data_o !== 32'h0000F00D) begin
      bad++;
      $display("FAIL lhu_low: we=%b wd=%h, want 1 0000f00d", wr_en_o, wr_data_o);
    end
  endtask

  task automatic test_word_and_misalign();
    logic st, wo;
    logic [4:0]  sz_t [2] = '{5'd2, 5'd1};
    issue(5'd12, 1'b1, 2'b10, 1'b1, 32'h00003000);
    run_mem(0, 0, 32'h80000001, st, wo);
    total++;
    if ({wr_en_o, rd_addr_o, wr_data_o} !== {1'b1, 5'd12, 32'h80000001}) begin
      bad++;
      $display("FAIL lw_aligned: we=%b rd=%0d wd=%h, want 1 12 80000001", wr_en_o, rd_addr_o, wr_data_o);
    end
    // LW at 0x3001 then LH at 0x3001: both dropped with a single pulse
    for (int k = 0; k < 2; k++) begin
      issue(5'd13, 1'b1, sz_t[k][1:0], 1'b0, 32'h00003001);
      total++;
      if ({misalign_o, dmem_req_o, wr_en_o, ready_o} !== 4'b1001) begin
        bad++;
        $display("FAIL misalign_pulse%0d: mis=%b req=%b we=%b rdy=%b, want 1 0 0 1",
                 k, misalign_o, dmem_req_o, wr_en_o, ready_o);
      end
      @(negedge clk);
      total++;
      if ({misalign_o, dmem_req_o, wr_en_o} !== 3'b000) begin
        bad++;
        $display("FAIL misalign_after%0d: mis=%b req=%b we=%b, want 0 0 0",
                 k, misalign_o, dmem_req_o, wr_en_o);
      end
    end
  endtask

  task automatic test_load_x0();
    logic st, wo;
    issue(5'd0, 1'b1, 2'b10, 1'b0, 32'h00004000);
    total++;
    if (dmem_req_o !== 1'b1) begin
      bad++;
      $display("FAIL x0_req: req=%b, want 1", dmem_req_o);
    end
    run_mem(1, 1, 32'hCAFEF00D, st, wo);
    total++;
    if ({wr_en_o, ready_o, rd_addr_o, wr_data_o} !== {1'b0, 1'b1, 5'd12, 32'h80000001}) begin
      bad++;
      $display("FAIL x0_load: we=%b rdy=%b rd=%0d wd=%h, want 0 1 12 80000001",
               wr_en_o, ready_o, rd_addr_o, wr_data_o);
    end
  endtask

  task automatic test_back_to_back();
    logic st, wo;
    issue(5'd14, 1'b1, 2'b10, 1'b0, 32'h00005000);
    run_mem(0, 0, 32'h0BADC0DE, st, wo);
    // accepted in the load's write cycle
    valid_i = 1'b1; rd_addr_i = 5'd15; is_load_i = 1'b0; alu_res_i = 32'h00000111;
    total++;
    if ({wr_en_o, rd_addr_o, wr_data_o, ready_o} !== {1'b1, 5'd14, 32'h0BADC0DE, 1'b1}) begin
      bad++;
      $display("FAIL b2b_load: we=%b rd=%0d wd=%h rdy=%b, want 1 14 0badc0de 1",
               wr_en_o, rd_addr_o, wr_data_o, ready_o);
    end
    @(negedge clk);
    rd_addr_i = 5'd16; alu_res_i = 32'h00000222;
    total++;
    if ({wr_en_o, rd_addr_o, wr_data_o} !== {1'b1, 5'd15, 32'h00000111}) begin
      bad++;
      $display("FAIL b2b_alu1: we=%b rd=%0d wd=%h, want 1 15 00000111", wr_en_o, rd_addr_o, wr_data_o);
    end
    @(negedge clk);
    valid_i = 1'b0;
    total++;
    if ({wr_en_o, rd_addr_o, wr_data_o} !== {1'b1, 5'd16, 32'h00000222}) begin
      bad++;
      $display("FAIL b2b_alu2: we=%b rd=%0d wd=%h, want 1 16 00000222", wr_en_o, rd_addr_o, wr_data_o);
    end
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    total++;
    if ({wr_en_o, dmem_req_o, ready_o} !== 3'b001) begin
      bad++;
      $display("FAIL stray_idle: we=%b req=%b rdy=%b, want 0 0 1", wr_en_o, dmem_req_o, ready_o);
    end
  endtask

  task automatic test_reset_mid_load();
    issue(5'd20, 1'b1, 2'b10, 1'b0, 32'h00006000);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({dmem_req_o, dmem_addr_o, ready_o} !== {1'b0, 32'h0, 1'b1}) begin
      bad++;
      $display("FAIL rst_in_req: req=%b addr=%h rdy=%b, want 0 00000000 1", dmem_req_o, dmem_addr_o, ready_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    issue(5'd21, 1'b1, 2'b10, 1'b0, 32'h00007000);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({dmem_req_o, ready_o, wr_en_o} !== 3'b010) begin
      bad++;
      $display("FAIL rst_in_wait: req=%b rdy=%b we=%b, want 0 1 0", dmem_req_o, ready_o, wr_en_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h55555555;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    total++;
    if ({wr_en_o, dmem_req_o, ready_o, wr_data_o} !== {3'b001, 32'h0}) begin
      bad++;
      $display("FAIL late_rvalid: we=%b req=%b rdy=%b wd=%h, want 0 0 1 00000000",
               wr_en_o, dmem_req_o, ready_o, wr_data_o);
    end
    issue(5'd7, 1'b0, 2'b00, 1'b0, 32'h00001234);
    total++;
    if ({wr_en_o, rd_addr_o, wr_data_o} !== {1'b1, 5'd7, 32'h00001234}) begin
      bad++;
      $display("FAIL post_rst_alu: we=%b rd=%0d wd=%h, want 1 7 00001234", wr_en_o, rd_addr_o, wr_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb();
    test_lh_delayed();
    test_word_and_misalign();
    test_load_x0();
    test_back_to_back();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yarp_load_wb.md
# yarp_load_wb

Writeback stage of the YARP core. It sits directly upstream of the register file. It accepts one retiring instruction at a time from execute. ALU results are written back after one cycle. Loads run a request/grant/response transaction on the data-memory port, then their data is byte-selected and sign- or zero-extended before being written to the register file.

## Interface
Parameters:
- None; XLEN fixed at 32.

Ports:
- clk  input  1  core clock, all state on rising edge
- reset_n  input  1  reset; asynchronous, active-low
- valid_i  input  1  execute presents an instruction this cycle
- ready_o  output  1  block can accept; high only in IDLE (combinational from state)
- rd_addr_i  input  5  destination register
- is_load_i  input  1  1 = load, 0 = ALU result
- load_size_i  input  2  00 byte, 01 half, 10/11 word
- load_zext_i  input  1  1 = zero-extend (LBU/LHU), 0 = sign-extend
- alu_res_i  input  32  ALU result (non-load) or effective address (load)
- dmem_req_o  output  1  data-memory request
- dmem_addr_o  output  32  word-aligned request address, bits [1:0] = 0
- dmem_gnt_i  input  1  memory accepts request this cycle
- dmem_rvalid_i  input  1  read data valid
- dmem_rdata_i  input  32  read word
- wr_en_o  output  1  register-file write enable (registered)
- rd_addr_o  output  5  register-file write address (registered)
- wr_data_o  output  32  register-file write data (registered)
- misalign_o  output  1  one-cycle pulse: misaligned load dropped (registered)

## Operation
- FSM states: IDLE, REQ, WAIT. Transfer occurs when valid_i && ready_o.
- IDLE, non-load accepted: next edge drives wr_en_o=1, rd_addr_o=rd_addr_i, wr_data_o=alu_res_i. Stay in IDLE.
- IDLE, load accepted and aligned:
  - Latch rd_addr, size, zext, and addr[1:0].
  - Latch the address as {alu_res_i[31:2],2'b00}.
  - Go to REQ.
- Misaligned load: half with addr[0]=1, or word with addr[1:0]!=0.
  - Next edge pulses misalign_o=1.
  - No memory request and no write. Stay in IDLE.
- REQ:
  - dmem_req_o=1. dmem_addr_o is held stable until grant.
  - On dmem_gnt_i, go to WAIT; dmem_req_o drops on the next cycle.
  - Grant may take any number of cycles.
- WAIT:
  - dmem_req_o=0.
  - On dmem_rvalid_i, the next edge drives wr_en_o=1 with extracted data and rd_addr_o = latched rd. Go to IDLE.
- Extraction (off = latched addr[1:0]):
  - Byte: rdata[8*off+7 : 8*off].
  - Half: rdata[16*off[1]+15 : 16*off[1]].
  - Word: rdata unchanged.
  - Extension to 32 bits uses bit 7 or bit 15 unless zext=1. zext is ignored for word loads.
- rd = x0: every operation, including the memory transaction, proceeds normally, but wr_en_o stays 0.
- dmem_rvalid_i outside WAIT and dmem_gnt_i outside REQ are ignored.
- wr_en_o and misalign_o are 0 in every cycle not listed above. rd_addr_o and wr_data_o hold their last value when wr_en_o=0.

## Timing
- Reset values: state IDLE, dmem_req_o=0, dmem_addr_o=0, wr_en_o=0, rd_addr_o=0, wr_data_o=0, misalign_o=0. ready_o=1.
- ALU latency: accept at edge N, wr_en_o high during cycle N+1 for exactly one cycle.
- Load latency (minimum 3 cycles from accept to write):
  - Accept at edge N; REQ during cycle N+1.
  - Grant in cycle N+1 gives WAIT in cycle N+2.
  - rvalid in cycle N+2 gives wr_en_o in cycle N+3.
- Back-to-back:
  - An instruction accepted in the cycle wr_en_o is high writes one cycle later. No bubble after an ALU op.
  - ready_o=0 throughout REQ and WAIT. Execute must hold its inputs.
- Reset mid-load (REQ or WAIT):
  - dmem_req_o drops asynchronously and the load is abandoned with no write.
  - A late dmem_rvalid_i after reset is ignored.
- Hazard forwarding is not this block's job. The register file observes a write one edge after wr_en_o.

## Test plan
- Reset, then ALU op rd=5, alu_res=0xDEADBEEF -> wr_en_o=1 one cycle later with rd_addr_o=5, wr_data_o=0xDEADBEEF. ready_o stays 1.
- LB to rd=3, addr=0x1003, gnt same cycle, rdata=0x80xxxxxx next cycle:
  - dmem_addr_o=0x1000.
  - wr_data_o=0xFFFFFF80 at accept+3.
  - The same access as LBU gives 0x00000080.
- LH at addr=0x2002 with 4-cycle grant delay and 2-cycle rvalid delay:
  - dmem_req_o and dmem_addr_o stay stable until gnt; ready_o=0 throughout.
  - Write carries sign-extended rdata[31:16].
- LW at 0x3001 -> misalign_o pulses once, dmem_req_o never asserts, no write. Word loads at 0x3000 and LH at 0x3001 behave analogously (aligned loads, misaligned drop).
- Load to x0 -> memory transaction completes, wr_en_o stays 0. An ALU op to rd=0 also gives no write.
- Reset asserted in WAIT, rvalid pulsed after release -> no write, dmem_req_o=0, ready_o=1, next ALU op writes normally.
